// File: rtl/transpad_pkg.sv
// Shared types and constants for the transpad arbiter and its picker.
// Build option: TRANSPAD_ARB_TMO_EN enables the WAIT_ACT watchdog in transpad_arb.
package transpad_pkg;

  localparam int CMD_W  = 3;
  localparam int DATA_W = 48;
  localparam logic [CMD_W-1:0] CMD_NOP = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACT,
    RUN
  } arb_state_t;

endpackage

// File: rtl/transpad_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping modulo NREQ.
module transpad_rr_pick #(
  parameter int NREQ  = 2,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic             any_o
);

  localparam logic [PTR_W:0] NREQ_EXT = (PTR_W+1)'(NREQ);

  logic [PTR_W:0] idx;
  logic           found;

  // One extra bit on idx lets ptr+i exceed NREQ-1 before the wrap subtract.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr_i} + (PTR_W+1)'(i);
      if (idx >= NREQ_EXT) begin
        idx = idx - NREQ_EXT;
      end
      if (!found && req_i[idx[PTR_W-1:0]]) begin
        gnt_o[idx[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/transpad_arb.sv
// Round-robin arbiter/command sequencer sharing one transpad generator.
// Build option: TRANSPAD_ARB_TMO_EN adds a WAIT_ACT watchdog (TMO_CYC cycles).
module transpad_arb
  import transpad_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TMO_CYC = 64
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0][CMD_W-1:0]   req_cmd,
  input  logic [NREQ-1:0][DATA_W-1:0]  req_data,
  input  logic [NREQ-1:0]              req_last,
  output logic [NREQ-1:0]              req_ready,
  output logic [NREQ-1:0]              gnt,
  output logic [NREQ-1:0]              done,
  output logic                         busy,
  output logic                         err,
  output logic [CMD_W-1:0]             tp_cmd,
  output logic [DATA_W-1:0]            tp_data,
  input  logic                         tp_act
);

  localparam int PTR_W = $clog2(NREQ);

  arb_state_t          state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic [NREQ-1:0]     pick_gnt;
  logic                pick_any;
  logic [CMD_W-1:0]    sel_cmd;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_last;
  logic [PTR_W-1:0]    gidx;
  logic [PTR_W-1:0]    nxt_ptr;
  logic                hs;

  transpad_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .any_o (pick_any)
  );

  // Beat mux and binary index of the current owner (gnt_q is one-hot or zero).
  always_comb begin
    sel_cmd  = CMD_NOP;
    sel_data = '0;
    sel_last = 1'b0;
    gidx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        sel_cmd  = req_cmd[i];
        sel_data = req_data[i];
        sel_last = req_last[i];
        gidx     = PTR_W'(i);
      end
    end
  end

  assign nxt_ptr   = (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + PTR_W'(1);
  assign req_ready = (state_q == ISSUE) ? gnt_q : '0;
  assign hs        = |(req_valid & req_ready);

`ifdef TRANSPAD_ARB_TMO_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit;
  logic             err_q;

  // Counter is zero whenever we are outside WAIT_ACT, so it restarts on entry.
  assign tmo_hit   = (state_q == WAIT_ACT) && !tp_act && (tmo_cnt_q == TMO_MAX);
  assign tmo_cnt_d = (state_q == WAIT_ACT) ? tmo_cnt_q + TMO_W'(1) : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= tmo_hit;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cmd_d   = CMD_NOP;
    data_d  = data_q;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_gnt;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (hs) begin
          cmd_d  = sel_cmd;
          data_d = sel_data;
          if (sel_last) begin
            state_d = WAIT_ACT;
          end
        end
      end
      WAIT_ACT: begin
        if (tp_act) begin
          state_d = RUN;
        end
`ifdef TRANSPAD_ARB_TMO_EN
        else if (tmo_hit) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
          state_d = IDLE;
        end
`endif
      end
      RUN: begin
        if (!tp_act) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      ptr_q   <= '0;
      cmd_q   <= CMD_NOP;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);
  assign tp_cmd  = cmd_q;
  assign tp_data = data_q;

endmodule

// File: tb/tb_transpad_arb.sv
// Directed self-checking bench for transpad_arb (NREQ=2, TMO_CYC=8).
// The watchdog scenario runs only when TRANSPAD_ARB_TMO_EN is defined.
module tb_transpad_arb;

  logic             clk;
  logic             rstn;
  logic [1:0]       req_valid;
  logic [1:0][2:0]  req_cmd;
  logic [1:0][47:0] req_data;
  logic [1:0]       req_last;
  logic [1:0]       req_ready;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             busy;
  logic             err;
  logic [2:0]       tp_cmd;
  logic [47:0]      tp_data;
  logic             tp_act;

  int passed;
  int total;

  logic [2:0]  prog_cmd  [2][4];
  logic [47:0] prog_data [2][4];
  int          prog_len  [2];
  int          beat_idx  [2];
  bit          active    [2];
  bit          hold      [2];

  transpad_arb #(
    .NREQ    (2),
    .TMO_CYC (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .err       (err),
    .tp_cmd    (tp_cmd),
    .tp_data   (tp_data),
    .tp_act    (tp_act)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Requester model: each port streams its loaded program, advancing on handshakes.
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      int b;
      b = (beat_idx[i] < 4) ? beat_idx[i] : 3;
      req_valid[i] = active[i] && !hold[i] && (beat_idx[i] < prog_len[i]);
      req_cmd[i]   = prog_cmd[i][b];
      req_data[i]  = prog_data[i][b];
      req_last[i]  = (beat_idx[i] == prog_len[i] - 1);
    end
  endtask

  task automatic tick();
    logic [1:0] hs;
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (hs[i]) begin
        beat_idx[i]++;
        if (beat_idx[i] >= prog_len[i]) active[i] = 1'b0;
      end
    end
    drive();
  endtask

  task automatic set_beat(input int p, input int k, input logic [2:0] c, input logic [47:0] d);
    prog_cmd[p][k]  = c;
    prog_data[p][k] = d;
  endtask

  task automatic start(input int p, input int len);
    prog_len[p] = len;
    beat_idx[p] = 0;
    active[p]   = 1'b1;
    hold[p]     = 1'b0;
  endtask

  task automatic test_reset();
    rstn   = 1'b0;
    tp_act = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prog_len[i] = 0; beat_idx[i] = 0; active[i] = 1'b0; hold[i] = 1'b0;
      for (int k = 0; k < 4; k++) set_beat(i, k, 3'b000, 48'h0);
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    total++; if (gnt !== 2'b00) $display("[TB] FAIL reset_gnt: got %b expected 00", gnt); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 2'b00) $display("[TB] FAIL reset_done: got %b expected 00", done); else passed++;
    total++; if (req_ready !== 2'b00) $display("[TB] FAIL reset_ready: got %b expected 00", req_ready); else passed++;
    total++; if (tp_cmd !== 3'b000 || tp_data !== 48'h0) $display("[TB] FAIL reset_tp: got %b/%h expected 000/0", tp_cmd, tp_data); else passed++;
    total++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err); else passed++;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int bad;
    set_beat(1, 0, 3'b000, 48'h55);
    set_beat(1, 1, 3'b001, 48'h1234);
    set_beat(1, 2, 3'b101, 48'hABC);
    start(1, 3);
    drive();
    tick();
    total++; if (gnt !== 2'b10) $display("[TB] FAIL single_gnt: got %b expected 10", gnt); else passed++;
    total++; if (req_ready !== 2'b10) $display("[TB] FAIL single_ready: got %b expected 10", req_ready); else passed++;
    total++; if (busy !== 1'b1) $display("[TB] FAIL single_busy: got %b expected 1", busy); else passed++;
    tick();
    total++; if (tp_cmd !== 3'b000 || tp_data !== 48'h55) $display("[TB] FAIL single_beat0: got %b/%h expected 000/55", tp_cmd, tp_data); else passed++;
    tick();
    total++; if (tp_cmd !== 3'b001 || tp_data !== 48'h1234) $display("[TB] FAIL single_beat1: got %b/%h expected 001/1234", tp_cmd, tp_data); else passed++;
    tick();
    total++; if (tp_cmd !== 3'b101 || tp_data !== 48'hABC) $display("[TB] FAIL single_beat2: got %b/%h expected 101/abc", tp_cmd, tp_data); else passed++;
    total++; if (req_ready !== 2'b00) $display("[TB] FAIL single_wait_ready: got %b expected 00", req_ready); else passed++;
    tp_act = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (done !== 2'b00 || gnt !== 2'b10 || tp_cmd !== 3'b000) bad++;
    end
    total++; if (bad !== 0) $display("[TB] FAIL single_run_hold: got %0d bad cycles expected 0", bad); else passed++;
    tp_act = 1'b0;
    tick();
    total++; if (done !== 2'b10) $display("[TB] FAIL single_done: got %b expected 10", done); else passed++;
    total++; if (gnt !== 2'b00 || busy !== 1'b0) $display("[TB] FAIL single_release: got gnt %b busy %b expected 00/0", gnt, busy); else passed++;
    tick();
    total++; if (done !== 2'b00) $display("[TB] FAIL single_done_pulse: got %b expected 00", done); else passed++;
  endtask

  // Pointer is back at 0 here, so requester 0 must win the tie.
  task automatic test_both();
    int bad;
    set_beat(0, 0, 3'b010, 48'h111);
    set_beat(0, 1, 3'b110, 48'h222);
    set_beat(1, 0, 3'b011, 48'h333);
    start(0, 2);
    start(1, 1);
    drive();
    tick();
    total++; if (gnt !== 2'b01) $display("[TB] FAIL both_first_gnt: got %b expected 01", gnt); else passed++;
    total++; if (req_ready !== 2'b01) $display("[TB] FAIL both_first_ready: got %b expected 01", req_ready); else passed++;
    bad = 0;
    tick();
    if (req_ready[1] !== 1'b0 || req_valid[1] !== 1'b1) bad++;
    total++; if (tp_cmd !== 3'b010 || tp_data !== 48'h111) $display("[TB] FAIL both_beat0: got %b/%h expected 010/111", tp_cmd, tp_data); else passed++;
    tick();
    if (req_ready[1] !== 1'b0) bad++;
    total++; if (tp_cmd !== 3'b110 || tp_data !== 48'h222) $display("[TB] FAIL both_beat1: got %b/%h expected 110/222", tp_cmd, tp_data); else passed++;
    tp_act = 1'b1;
    tick();
    if (req_ready[1] !== 1'b0) bad++;
    total++; if (busy !== 1'b1 || gnt !== 2'b01) $display("[TB] FAIL fast_act_run: got busy %b gnt %b expected 1/01", busy, gnt); else passed++;
    tp_act = 1'b0;
    tick();
    total++; if (bad !== 0) $display("[TB] FAIL both_other_ready: got %0d bad cycles expected 0", bad); else passed++;
    total++; if (done !== 2'b01 || busy !== 1'b0) $display("[TB] FAIL fast_act_done: got done %b busy %b expected 01/0", done, busy); else passed++;
    total++; if (err !== 1'b0) $display("[TB] FAIL both_err: got %b expected 0", err); else passed++;
    tick();
    total++; if (gnt !== 2'b10 || req_ready !== 2'b10) $display("[TB] FAIL both_second_gnt: got gnt %b ready %b expected 10/10", gnt, req_ready); else passed++;
    tick();
    total++; if (tp_cmd !== 3'b011 || tp_data !== 48'h333) $display("[TB] FAIL both_second_beat: got %b/%h expected 011/333", tp_cmd, tp_data); else passed++;
    tp_act = 1'b1;
    tick();
    tp_act = 1'b0;
    tick();
    total++; if (done !== 2'b10) $display("[TB] FAIL both_second_done: got %b expected 10", done); else passed++;
    tick();
  endtask

  task automatic test_stall();
    int bad;
    set_beat(0, 0, 3'b001, 48'hA0);
    set_beat(0, 1, 3'b010, 48'hB0);
    set_beat(0, 2, 3'b011, 48'hC0);
    set_beat(0, 3, 3'b111, 48'hD0);
    start(0, 4);
    drive();
    tick();
    total++; if (gnt !== 2'b01) $display("[TB] FAIL stall_gnt: got %b expected 01", gnt); else passed++;
    tick();
    total++; if (tp_cmd !== 3'b001 || tp_data !== 48'hA0) $display("[TB] FAIL stall_beat0: got %b/%h expected 001/a0", tp_cmd, tp_data); else passed++;
    hold[0] = 1'b1;
    drive();
    bad = 0;
    repeat (3) begin
      tick();
      if (tp_cmd !== 3'b000 || tp_data !== 48'hA0 || gnt !== 2'b01 || busy !== 1'b1) bad++;
    end
    total++; if (bad !== 0) $display("[TB] FAIL stall_nop_hold: got %0d bad cycles expected 0", bad); else passed++;
    hold[0] = 1'b0;
    drive();
    tick();
    total++; if (tp_cmd !== 3'b010 || tp_data !== 48'hB0) $display("[TB] FAIL stall_beat1: got %b/%h expected 010/b0", tp_cmd, tp_data); else passed++;
    tick();
    total++; if (tp_cmd !== 3'b011 || tp_data !== 48'hC0) $display("[TB] FAIL stall_beat2: got %b/%h expected 011/c0", tp_cmd, tp_data); else passed++;
    tick();
    total++; if (tp_cmd !== 3'b111 || tp_data !== 48'hD0) $display("[TB] FAIL stall_beat3: got %b/%h expected 111/d0", tp_cmd, tp_data); else passed++;
    tp_act = 1'b1;
    tick();
    tp_act = 1'b0;
    tick();
    total++; if (done !== 2'b01) $display("[TB] FAIL stall_done: got %b expected 01", done); else passed++;
    tick();
  endtask

  // Reset lands while requester 1 owns the generator; the pointer must return to 0.
  task automatic test_reset_run();
    set_beat(1, 0, 3'b100, 48'h44);
    start(1, 1);
    drive();
    tick();
    total++; if (gnt !== 2'b10) $display("[TB] FAIL rstrun_gnt: got %b expected 10", gnt); else passed++;
    tick();
    tp_act = 1'b1;
    tick();
    total++; if (busy !== 1'b1) $display("[TB] FAIL rstrun_busy: got %b expected 1", busy); else passed++;
    #2;
    rstn = 1'b0;
    #1;
    total++; if (gnt !== 2'b00 || busy !== 1'b0) $display("[TB] FAIL rstrun_async: got gnt %b busy %b expected 00/0", gnt, busy); else passed++;
    total++; if (tp_cmd !== 3'b000 || tp_data !== 48'h0 || req_ready !== 2'b00) $display("[TB] FAIL rstrun_tp: got %b/%h/%b expected 000/0/00", tp_cmd, tp_data, req_ready); else passed++;
    tp_act = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    set_beat(0, 0, 3'b001, 48'h10);
    set_beat(1, 0, 3'b010, 48'h20);
    start(0, 1);
    start(1, 1);
    drive();
    tick();
    total++; if (gnt !== 2'b01) $display("[TB] FAIL rstrun_ptr: got %b expected 01", gnt); else passed++;
    tick();
    tp_act = 1'b1;
    tick();
    tp_act = 1'b0;
    tick();
    total++; if (done !== 2'b01) $display("[TB] FAIL rstrun_done0: got %b expected 01", done); else passed++;
    tick();
    total++; if (gnt !== 2'b10) $display("[TB] FAIL rstrun_gnt1: got %b expected 10", gnt); else passed++;
    tick();
    total++; if (tp_cmd !== 3'b010 || tp_data !== 48'h20) $display("[TB] FAIL rstrun_beat1: got %b/%h expected 010/20", tp_cmd, tp_data); else passed++;
    tp_act = 1'b1;
    tick();
    tp_act = 1'b0;
    tick();
    total++; if (done !== 2'b10) $display("[TB] FAIL rstrun_done1: got %b expected 10", done); else passed++;
    tick();
  endtask

`ifdef TRANSPAD_ARB_TMO_EN
  task automatic test_timeout();
    int bad;
    set_beat(0, 0, 3'b011, 48'h30);
    set_beat(1, 0, 3'b100, 48'h40);
    start(0, 1);
    start(1, 1);
    drive();
    tick();
    total++; if (gnt !== 2'b01) $display("[TB] FAIL tmo_gnt0: got %b expected 01", gnt); else passed++;
    tick();
    total++; if (tp_cmd !== 3'b011) $display("[TB] FAIL tmo_beat: got %b expected 011", tp_cmd); else passed++;
    bad = 0;
    repeat (7) begin
      tick();
      if (err !== 1'b0 || done !== 2'b00 || gnt !== 2'b01) bad++;
    end
    total++; if (bad !== 0) $display("[TB] FAIL tmo_wait: got %0d bad cycles expected 0", bad); else passed++;
    tick();
    total++; if (err !== 1'b1 || done !== 2'b01) $display("[TB] FAIL tmo_fire: got err %b done %b expected 1/01", err, done); else passed++;
    total++; if (gnt !== 2'b00 || busy !== 1'b0) $display("[TB] FAIL tmo_release: got gnt %b busy %b expected 00/0", gnt, busy); else passed++;
    tick();
    total++; if (err !== 1'b0 || gnt !== 2'b10) $display("[TB] FAIL tmo_next: got err %b gnt %b expected 0/10", err, gnt); else passed++;
    tick();
    tp_act = 1'b1;
    tick();
    tp_act = 1'b0;
    tick();
    total++; if (done !== 2'b10) $display("[TB] FAIL tmo_next_done: got %b expected 10", done); else passed++;
    tick();
  endtask
`endif

  initial begin
    passed    = 0;
    total     = 0;
    req_valid = '0;
    req_cmd   = '0;
    req_data  = '0;
    req_last  = '0;
    test_reset();
    test_single();
    test_both();
    test_stall();
    test_reset_run();
`ifdef TRANSPAD_ARB_TMO_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
